// File: rtl/rtc_pkg.sv
// Shared types and constants for the DS1302 scheduling logic: FSM states,
// the seven-byte time record, BCD limits and DS1302 register addresses.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BUSY,
    ST_RD_BUSY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic [7:0] date;
    logic [7:0] month;
    logic [7:0] week;
    logic [7:0] year;
  } rtc_time_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] DATE_MIN = 8'h01;
  localparam logic [7:0] DATE_MAX = 8'h31;
  localparam logic [7:0] MON_MIN  = 8'h01;
  localparam logic [7:0] MON_MAX  = 8'h12;
  localparam logic [7:0] WEEK_MIN = 8'h01;
  localparam logic [7:0] WEEK_MAX = 8'h07;
  localparam logic [7:0] YEAR_MAX = 8'h99;

  // DS1302 write-command addresses; the read address is the same value with bit0 set
  localparam logic [7:0] ADDR_SEC   = 8'h80;
  localparam logic [7:0] ADDR_MIN   = 8'h82;
  localparam logic [7:0] ADDR_HOUR  = 8'h84;
  localparam logic [7:0] ADDR_DATE  = 8'h86;
  localparam logic [7:0] ADDR_MONTH = 8'h88;
  localparam logic [7:0] ADDR_WEEK  = 8'h8A;
  localparam logic [7:0] ADDR_YEAR  = 8'h8C;
  localparam logic [7:0] ADDR_WP    = 8'h8E;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational validator for a requested time: every byte must be legal BCD
// and each field must sit inside its calendar range in 24-hour, clock-running mode.
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [7:0] second_i,
  input  logic [7:0] minute_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] date_i,
  input  logic [7:0] month_i,
  input  logic [7:0] week_i,
  input  logic [7:0] year_i,
  output logic       valid_o
);

  logic digits_ok;
  logic ranges_ok;

  assign digits_ok = bcd_ok(second_i) && bcd_ok(minute_i) && bcd_ok(hour_i) &&
                     bcd_ok(date_i) && bcd_ok(month_i) && bcd_ok(week_i) &&
                     bcd_ok(year_i);

  // Bit7 of second is the clock-halt flag and bit7 of hour selects 12h mode; both must stay 0
  assign ranges_ok = (second_i <= SEC_MAX) && !second_i[7] &&
                     (minute_i <= MIN_MAX) &&
                     (hour_i <= HOUR_MAX) && !hour_i[7] &&
                     (date_i >= DATE_MIN) && (date_i <= DATE_MAX) &&
                     (month_i >= MON_MIN) && (month_i <= MON_MAX) &&
                     (week_i >= WEEK_MIN) && (week_i <= WEEK_MAX) &&
                     (year_i <= YEAR_MAX);

  assign valid_o = digits_ok && ranges_ok;

endmodule

// File: rtl/rtc_scheduler.sv
// Arbitrates DS1302 read polls and time-set writes so only one transaction is
// outstanding, keeps the last good time snapshot and watches for stuck transactions.
module rtc_scheduler
  import rtc_pkg::*;
#(
  parameter int POLL_CYCLES    = 5_000_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_en,
  input  logic       force_read,
  input  logic       set_req,
  input  logic [7:0] set_second,
  input  logic [7:0] set_minute,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_date,
  input  logic [7:0] set_month,
  input  logic [7:0] set_week,
  input  logic [7:0] set_year,
  output logic       set_done,
  output logic       set_reject,
  input  logic       err_clr,
  output logic       write_time_req,
  output logic [7:0] wr_second,
  output logic [7:0] wr_minute,
  output logic [7:0] wr_hour,
  output logic [7:0] wr_date,
  output logic [7:0] wr_month,
  output logic [7:0] wr_week,
  output logic [7:0] wr_year,
  output logic       read_time_req,
  input  logic       time_ack,
  input  logic [7:0] rtc_second,
  input  logic [7:0] rtc_minute,
  input  logic [7:0] rtc_hour,
  input  logic [7:0] rtc_date,
  input  logic [7:0] rtc_month,
  input  logic [7:0] rtc_week,
  input  logic [7:0] rtc_year,
  output logic [7:0] time_second,
  output logic [7:0] time_minute,
  output logic [7:0] time_hour,
  output logic [7:0] time_date,
  output logic [7:0] time_month,
  output logic [7:0] time_week,
  output logic [7:0] time_year,
  output logic       time_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_MAX    = CNT_W'(TIMEOUT_CYCLES);

  state_e     state_q, state_d;
  logic [CNT_W-1:0] poll_q, poll_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic       rd_pend_q, rd_pend_d;
  logic       wr_pend_q, wr_pend_d;
  logic       wreq_q, wreq_d;
  logic       rreq_q, rreq_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       tvalid_q, tvalid_d;
  logic       err_q, err_d;
  rtc_time_t  shadow_q, shadow_d;
  rtc_time_t  snap_q, snap_d;
  rtc_time_t  set_time, rtc_time;
  logic       set_valid;
  logic       set_accept;

  assign set_time = {set_second, set_minute, set_hour, set_date, set_month, set_week, set_year};
  assign rtc_time = {rtc_second, rtc_minute, rtc_hour, rtc_date, rtc_month, rtc_week, rtc_year};

  rtc_bcd_check u_bcd_check (
    .second_i (set_second),
    .minute_i (set_minute),
    .hour_i   (set_hour),
    .date_i   (set_date),
    .month_i  (set_month),
    .week_i   (set_week),
    .year_i   (set_year),
    .valid_o  (set_valid)
  );

  // The shadow is frozen while a write is on the wire
  assign set_accept = set_req && set_valid && (state_q != ST_WR_BUSY);

  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    wd_d      = '0;
    rd_pend_d = rd_pend_q;
    wr_pend_d = wr_pend_q;
    wreq_d    = wreq_q;
    rreq_d    = rreq_q;
    done_d    = 1'b0;
    reject_d  = set_req && !set_accept;
    tvalid_d  = 1'b0;
    err_d     = err_q && !err_clr;
    shadow_d  = shadow_q;
    snap_d    = snap_q;

    if (poll_en) begin
      if (poll_q == POLL_LAST) begin
        poll_d    = '0;
        rd_pend_d = 1'b1;
      end else begin
        poll_d = poll_q + 1'b1;
      end
    end else begin
      poll_d = '0;
    end

    if (force_read) rd_pend_d = 1'b1;

    if (set_accept) begin
      shadow_d  = set_time;
      wr_pend_d = 1'b1;
    end

    // Issuing a transaction consumes its pending flag, absorbing any same-cycle re-request
    case (state_q)
      ST_IDLE: begin
        if (wr_pend_q) begin
          state_d   = ST_WR_BUSY;
          wreq_d    = 1'b1;
          wr_pend_d = 1'b0;
        end else if (rd_pend_q) begin
          state_d   = ST_RD_BUSY;
          rreq_d    = 1'b1;
          rd_pend_d = 1'b0;
        end
      end
      ST_WR_BUSY, ST_RD_BUSY: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        if (wd_q == WD_LAST) err_d = 1'b1;
        if (time_ack) begin
          state_d = ST_GAP;
          if (state_q == ST_WR_BUSY) begin
            wreq_d    = 1'b0;
            done_d    = 1'b1;
            rd_pend_d = 1'b1;
          end else begin
            rreq_d   = 1'b0;
            snap_d   = rtc_time;
            tvalid_d = 1'b1;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      poll_q    <= '0;
      wd_q      <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      wreq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      wd_q      <= wd_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      wreq_q    <= wreq_d;
      rreq_q    <= rreq_d;
      done_q    <= done_d;
      reject_q  <= reject_d;
      tvalid_q  <= tvalid_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      snap_q    <= snap_d;
    end
  end

  assign write_time_req = wreq_q;
  assign read_time_req  = rreq_q;
  assign set_done       = done_q;
  assign set_reject     = reject_q;
  assign time_valid     = tvalid_q;
  assign timeout_err    = err_q;
  assign busy           = (state_q != ST_IDLE);

  assign wr_second = shadow_q.sec;
  assign wr_minute = shadow_q.min;
  assign wr_hour   = shadow_q.hour;
  assign wr_date   = shadow_q.date;
  assign wr_month  = shadow_q.month;
  assign wr_week   = shadow_q.week;
  assign wr_year   = shadow_q.year;

  assign time_second = snap_q.sec;
  assign time_minute = snap_q.min;
  assign time_hour   = snap_q.hour;
  assign time_date   = snap_q.date;
  assign time_month  = snap_q.month;
  assign time_week   = snap_q.week;
  assign time_year   = snap_q.year;

endmodule

// File: tb/tb_rtc_scheduler.sv
// Directed bench for rtc_scheduler with a small DS1302 ack responder and
// hand-computed cycle-exact expectations (POLL=10, TIMEOUT=50).
module tb_rtc_scheduler;

  logic       clk, rst, poll_en, force_read, set_req, err_clr, time_ack;
  logic [7:0] set_second, set_minute, set_hour, set_date, set_month, set_week, set_year;
  logic       set_done, set_reject, write_time_req, read_time_req, time_valid, busy, timeout_err;
  logic [7:0] wr_second, wr_minute, wr_hour, wr_date, wr_month, wr_week, wr_year;
  logic [7:0] mSec, mMin, mHour, mDate, mMon, mWeek, mYear;
  logic [7:0] time_second, time_minute, time_hour, time_date, time_month, time_week, time_year;

  int checkCount = 0;
  int failCount  = 0;
  int ackDelay   = 3;
  bit ackEnable  = 1'b0;
  int reqAge     = 0;
  int writeRise  = 0;
  int readRise   = 0;
  int doneCount  = 0;
  int tvCount    = 0;
  logic prevW = 1'b0;
  logic prevR = 1'b0;

  rtc_scheduler #(.POLL_CYCLES(10), .TIMEOUT_CYCLES(50), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .poll_en(poll_en), .force_read(force_read), .set_req(set_req),
    .set_second(set_second), .set_minute(set_minute), .set_hour(set_hour), .set_date(set_date),
    .set_month(set_month), .set_week(set_week), .set_year(set_year),
    .set_done(set_done), .set_reject(set_reject), .err_clr(err_clr),
    .write_time_req(write_time_req),
    .wr_second(wr_second), .wr_minute(wr_minute), .wr_hour(wr_hour), .wr_date(wr_date),
    .wr_month(wr_month), .wr_week(wr_week), .wr_year(wr_year),
    .read_time_req(read_time_req), .time_ack(time_ack),
    .rtc_second(mSec), .rtc_minute(mMin), .rtc_hour(mHour), .rtc_date(mDate),
    .rtc_month(mMon), .rtc_week(mWeek), .rtc_year(mYear),
    .time_second(time_second), .time_minute(time_minute), .time_hour(time_hour),
    .time_date(time_date), .time_month(time_month), .time_week(time_week), .time_year(time_year),
    .time_valid(time_valid), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DS1302 stand-in: acks ackDelay cycles after a request rises
  initial begin
    time_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      time_ack = 1'b0;
      if (!(write_time_req || read_time_req)) begin
        reqAge = 0;
      end else begin
        reqAge++;
        if (ackEnable && reqAge >= ackDelay) time_ack = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (write_time_req && !prevW) writeRise++;
      if (read_time_req && !prevR) readRise++;
      prevW = write_time_req;
      prevR = read_time_req;
      if (set_done) doneCount++;
      if (time_valid) tvCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one set_req cycle (optionally with force_read) and returns just after that edge
  task automatic applyStimulus(input logic [55:0] vals, input logic frc);
    {set_second, set_minute, set_hour, set_date, set_month, set_week, set_year} = vals;
    set_req    = 1'b1;
    force_read = frc;
    step(1);
    set_req    = 1'b0;
    force_read = 1'b0;
  endtask

  task automatic pulseForce();
    force_read = 1'b1;
    step(1);
    force_read = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((busy || write_time_req || read_time_req) && n < 200) begin
      step(1);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  logic [55:0] goodVals = {8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h24};
  logic [55:0] valsA    = {8'h10, 8'h20, 8'h08, 8'h15, 8'h07, 8'h03, 8'h99};
  logic [55:0] valsB    = {8'h11, 8'h21, 8'h09, 8'h16, 8'h08, 8'h04, 8'h98};
  logic [55:0] badVals [4];

  initial begin
    int w0, r0, d0, t0;
    badVals[0] = {8'h45, 8'h59, 8'h24, 8'h31, 8'h12, 8'h07, 8'h24};
    badVals[1] = {8'h45, 8'h5A, 8'h23, 8'h31, 8'h12, 8'h07, 8'h24};
    badVals[2] = {8'h45, 8'h59, 8'h23, 8'h00, 8'h12, 8'h07, 8'h24};
    badVals[3] = {8'h80, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h24};
    rst = 1'b0; poll_en = 1'b0; force_read = 1'b0; set_req = 1'b0; err_clr = 1'b0;
    {set_second, set_minute, set_hour, set_date, set_month, set_week, set_year} = '0;
    {mSec, mMin, mHour, mDate, mMon, mWeek, mYear} = {8'h30, 8'h15, 8'h12, 8'h05, 8'h06, 8'h03, 8'h24};
    step(3);
    checkOutput("rst write_time_req", {31'd0, write_time_req}, 32'd0);
    checkOutput("rst read_time_req", {31'd0, read_time_req}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("rst time_second", {24'd0, time_second}, 32'd0);

    $display("[TB] periodic poll");
    rst = 1'b1; poll_en = 1'b1; ackEnable = 1'b1; ackDelay = 3;
    step(10);
    checkOutput("poll1 not yet", {31'd0, read_time_req}, 32'd0);
    step(1);
    checkOutput("poll1 req", {31'd0, read_time_req}, 32'd1);
    step(3);
    checkOutput("poll1 time_valid", {31'd0, time_valid}, 32'd1);
    checkOutput("poll1 time_second", {24'd0, time_second}, 32'h30);
    checkOutput("poll1 time_minute", {24'd0, time_minute}, 32'h15);
    checkOutput("poll1 time_hour", {24'd0, time_hour}, 32'h12);
    checkOutput("poll1 time_year", {24'd0, time_year}, 32'h24);
    checkOutput("poll1 gap busy", {31'd0, busy}, 32'd1);
    checkOutput("poll1 req dropped", {31'd0, read_time_req}, 32'd0);
    step(1);
    checkOutput("poll1 tv pulse", {31'd0, time_valid}, 32'd0);
    checkOutput("poll1 idle", {31'd0, busy}, 32'd0);
    step(5);
    checkOutput("poll2 not yet", {31'd0, read_time_req}, 32'd0);
    step(1);
    checkOutput("poll2 req", {31'd0, read_time_req}, 32'd1);
    poll_en = 1'b0; mSec = 8'h31;
    step(3);
    checkOutput("poll2 time_valid", {31'd0, time_valid}, 32'd1);
    checkOutput("poll2 time_second", {24'd0, time_second}, 32'h31);
    step(1);
    checkOutput("poll2 tv pulse", {31'd0, time_valid}, 32'd0);

    $display("[TB] valid write");
    applyStimulus(goodVals, 1'b0);
    checkOutput("wr accepted no reject", {31'd0, set_reject}, 32'd0);
    checkOutput("wr req latency", {31'd0, write_time_req}, 32'd0);
    step(1);
    checkOutput("wr req", {31'd0, write_time_req}, 32'd1);
    checkOutput("wr_second", {24'd0, wr_second}, 32'h45);
    checkOutput("wr_minute", {24'd0, wr_minute}, 32'h59);
    checkOutput("wr_hour", {24'd0, wr_hour}, 32'h23);
    checkOutput("wr_date", {24'd0, wr_date}, 32'h31);
    checkOutput("wr_month", {24'd0, wr_month}, 32'h12);
    checkOutput("wr_week", {24'd0, wr_week}, 32'h07);
    checkOutput("wr_year", {24'd0, wr_year}, 32'h24);
    step(3);
    checkOutput("wr set_done", {31'd0, set_done}, 32'd1);
    checkOutput("wr req dropped", {31'd0, write_time_req}, 32'd0);
    step(1);
    checkOutput("wr done pulse", {31'd0, set_done}, 32'd0);
    step(1);
    checkOutput("readback req", {31'd0, read_time_req}, 32'd1);
    waitIdle("readback idle");

    $display("[TB] invalid writes");
    w0 = writeRise;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(badVals[i], 1'b0);
      checkOutput($sformatf("bad%0d reject", i), {31'd0, set_reject}, 32'd1);
      step(1);
      checkOutput($sformatf("bad%0d reject pulse", i), {31'd0, set_reject}, 32'd0);
      checkOutput($sformatf("bad%0d no write", i), {31'd0, write_time_req}, 32'd0);
    end
    step(2);
    checkOutput("bad no write rise", writeRise - w0, 32'd0);

    $display("[TB] set plus force_read, set during write");
    w0 = writeRise; r0 = readRise; d0 = doneCount; t0 = tvCount;
    ackDelay = 6;
    applyStimulus(valsA, 1'b1);
    step(1);
    checkOutput("combo write first", {31'd0, write_time_req}, 32'd1);
    checkOutput("combo read held", {31'd0, read_time_req}, 32'd0);
    applyStimulus(valsB, 1'b0);
    checkOutput("busy set rejected", {31'd0, set_reject}, 32'd1);
    checkOutput("shadow frozen", {24'd0, wr_second}, 32'h10);
    step(20);
    checkOutput("combo writes", writeRise - w0, 32'd1);
    checkOutput("combo reads", readRise - r0, 32'd1);
    checkOutput("combo done", doneCount - d0, 32'd1);
    checkOutput("combo tv", tvCount - t0, 32'd1);
    checkOutput("combo idle", {31'd0, busy}, 32'd0);

    $display("[TB] watchdog");
    ackEnable = 1'b0;
    pulseForce();
    step(1);
    checkOutput("wd req", {31'd0, read_time_req}, 32'd1);
    step(49);
    checkOutput("wd before limit", {31'd0, timeout_err}, 32'd0);
    step(1);
    checkOutput("wd timeout_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("wd req held", {31'd0, read_time_req}, 32'd1);
    t0 = tvCount;
    ackDelay = 1; ackEnable = 1'b1;
    waitIdle("wd late ack idle");
    step(2);
    checkOutput("wd late ack tv", tvCount - t0, 32'd1);
    checkOutput("wd err sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checkOutput("wd err cleared", {31'd0, timeout_err}, 32'd0);

    $display("[TB] reset during read");
    ackEnable = 1'b0;
    pulseForce();
    step(1);
    checkOutput("rst2 busy before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    step(1);
    checkOutput("rst2 read req", {31'd0, read_time_req}, 32'd0);
    checkOutput("rst2 busy", {31'd0, busy}, 32'd0);
    checkOutput("rst2 time_second", {24'd0, time_second}, 32'd0);
    checkOutput("rst2 wr_hour", {24'd0, wr_hour}, 32'd0);
    rst = 1'b1; poll_en = 1'b1; ackEnable = 1'b1; ackDelay = 3;
    step(10);
    checkOutput("rst2 poll not yet", {31'd0, read_time_req}, 32'd0);
    step(1);
    checkOutput("rst2 first poll", {31'd0, read_time_req}, 32'd1);
    poll_en = 1'b0;
    waitIdle("final idle");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
